stream_packet_sequencer: RTL and testbench

- Sequences the 128-bit metadata generator and a payload source into framed AXI-Stream packets: one header beat from the metadata stream, then N payload beats, with tlast on the final beat.
- Repeats for a programmed packet count, or runs continuously, with a configurable idle gap between packets.
- Sits between the metadata/payload generators and the downstream packet sink (DMA/FIFO). Owns the start/stop sequencing for both sources.

---
 rtl/stream_packet_sequencer.sv | 104 ++++++++++
 tb/tb_stream_packet_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_packet_sequencer.sv
// stream_packet_sequencer: frames one metadata header beat plus N payload beats into AXI-Stream packets,
// repeating for a programmed packet count (or until stop) with an idle gap between packets.
module stream_packet_sequencer #(
  parameter int DW = 128,
  parameter int CW = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] cfg_payload_beats,
  input  logic [CW-1:0] cfg_num_packets,
  input  logic [DW-1:0] meta_tdata,
  input  logic          meta_tvalid,
  output logic          meta_tready,
  input  logic [DW-1:0] data_tdata,
  input  logic          data_tvalid,
  output logic          data_tready,
  output logic [DW-1:0] axis_out_tdata,
  output logic          axis_out_tvalid,
  input  logic          axis_out_tready,
  output logic          axis_out_tlast,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pkt_count
);
  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, GAP, DRAIN} state_t;
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_t state;
  logic [CW-1:0] beats, num_packets, beat_cnt, pkts_issued, gap_cnt;
  logic stop_pending, load_ok, meta_hs, data_hs, out_hs, last_beat, run_end;
  assign load_ok = !axis_out_tvalid || axis_out_tready;
  assign meta_tready = state == HEADER && load_ok;
  assign data_tready = state == PAYLOAD && load_ok;
  assign meta_hs = meta_tvalid && meta_tready;
  assign data_hs = data_tvalid && data_tready;
  assign out_hs = axis_out_tvalid && axis_out_tready;
  assign last_beat = beat_cnt == beats - 1'b1;
  // num_packets of zero is continuous mode, so pkts_issued wrapping can never end the run
  assign run_end = stop_pending || (num_packets != '0 && pkts_issued + 1'b1 == num_packets);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      axis_out_tdata <= '0;
      axis_out_tvalid <= 1'b0;
      axis_out_tlast <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pkt_count <= '0;
      beats <= '0;
      num_packets <= '0;
      beat_cnt <= '0;
      pkts_issued <= '0;
      gap_cnt <= '0;
      stop_pending <= 1'b0;
    end else begin
      done <= 1'b0;
      if (meta_hs || data_hs) begin
        axis_out_tvalid <= 1'b1;
        axis_out_tdata <= meta_hs ? meta_tdata : data_tdata;
        axis_out_tlast <= data_hs && last_beat;
      end else if (load_ok) begin
        axis_out_tvalid <= 1'b0;
        axis_out_tlast <= 1'b0;
      end
      if (out_hs && axis_out_tlast && pkt_count != '1) pkt_count <= pkt_count + 1'b1;
      if (stop && state != IDLE) stop_pending <= 1'b1;
      case (state)
        IDLE: if (start) begin
          beats <= cfg_payload_beats == '0 ? CW'(1) : cfg_payload_beats;
          num_packets <= cfg_num_packets;
          pkts_issued <= '0;
          pkt_count <= '0;
          busy <= 1'b1;
          state <= HEADER;
        end
        HEADER: if (meta_hs) begin
          beat_cnt <= '0;
          state <= PAYLOAD;
        end
        PAYLOAD: if (data_hs) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (last_beat) begin
            pkts_issued <= pkts_issued + 1'b1;
            gap_cnt <= '0;
            state <= run_end ? DRAIN : GAP_CYCLES == 0 ? HEADER : GAP;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          state <= stop_pending ? DRAIN : gap_cnt == GAP_LAST ? HEADER : GAP;
        end
        DRAIN: if (!axis_out_tvalid || (out_hs && axis_out_tlast)) begin
          busy <= 1'b0;
          done <= 1'b1;
          stop_pending <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_packet_sequencer.sv
// tb_stream_packet_sequencer: random sources and sink against a packet-level scoreboard,
// plus a second instance with no inter-packet gap.
module tb_stream_packet_sequencer;
  localparam int DW = 128;
  localparam int CW = 16;
  localparam int GAP = 4;
  logic clk = 0, resetn = 0, start = 0, stop = 0, start2 = 0;
  logic [CW-1:0] cfg_payload_beats = '0, cfg_num_packets = '0;
  logic [DW-1:0] meta_tdata = '0, data_tdata = '0;
  logic meta_tvalid = 0, data_tvalid = 0, axis_out_tready = 0;
  logic meta_tready, data_tready, axis_out_tvalid, axis_out_tlast, busy, done;
  logic [DW-1:0] axis_out_tdata, tdata2;
  logic [CW-1:0] pkt_count, pc2;
  logic tvalid2, tlast2, mr2, dr2, busy2, done2;
  stream_packet_sequencer #(.DW(DW), .CW(CW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .cfg_payload_beats(cfg_payload_beats), .cfg_num_packets(cfg_num_packets),
    .meta_tdata(meta_tdata), .meta_tvalid(meta_tvalid), .meta_tready(meta_tready),
    .data_tdata(data_tdata), .data_tvalid(data_tvalid), .data_tready(data_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tvalid(axis_out_tvalid),
    .axis_out_tready(axis_out_tready), .axis_out_tlast(axis_out_tlast),
    .busy(busy), .done(done), .pkt_count(pkt_count));
  stream_packet_sequencer #(.DW(DW), .CW(CW), .GAP_CYCLES(0)) dut_nogap (
    .clk(clk), .resetn(resetn), .start(start2), .stop(1'b0),
    .cfg_payload_beats(cfg_payload_beats), .cfg_num_packets(cfg_num_packets),
    .meta_tdata(meta_tdata), .meta_tvalid(1'b1), .meta_tready(mr2),
    .data_tdata(data_tdata), .data_tvalid(1'b1), .data_tready(dr2),
    .axis_out_tdata(tdata2), .axis_out_tvalid(tvalid2),
    .axis_out_tready(1'b1), .axis_out_tlast(tlast2),
    .busy(busy2), .done(done2), .pkt_count(pc2));
  always #5 clk = ~clk;

  int vec = 0, miss = 0;
  logic [DW-1:0] mq[$], dq[$], eq[$];
  bit el[$];
  int midx, didx, oidx, v_pct, r_pct, stop_at, idle, done_cnt, cyc;
  int v2_cnt, v2_first, v2_last, l2_cnt, done2_cnt;
  bit m_hs, d_hs, stalled, exp_done, seen_beat, prev_beat_last, full, start_req, start2_req;
  logic [DW-1:0] prev_data, want;
  logic prev_last;

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // expected output: per packet, its header then its payload beats, tlast on the final payload beat
  task automatic build(input int b, input int pm, input int ps);
    int be;
    be = b == 0 ? 1 : b;
    mq.delete(); dq.delete(); eq.delete(); el.delete();
    for (int p = 0; p < ps; p++) begin
      mq.push_back(p == 0 ? DW'('h666) : rnd());
      for (int i = 0; i < be; i++) dq.push_back(rnd());
    end
    for (int p = 0; p < pm; p++) begin
      eq.push_back(mq[p]); el.push_back(1'b0);
      for (int i = 0; i < be; i++) begin
        eq.push_back(dq[p * be + i]); el.push_back(i == be - 1);
      end
    end
    midx = 0; didx = 0; oidx = 0; idle = 0; done_cnt = 0;
    m_hs = 0; d_hs = 0; stalled = 0; exp_done = 0; seen_beat = 0; prev_beat_last = 0;
    cfg_payload_beats = CW'(b);
  endtask

  task automatic tick();
    @(negedge clk);
    if (m_hs) midx++;
    if (d_hs) didx++;
    start = start_req; start_req = 0;
    start2 = start2_req; start2_req = 0;
    stop = stop_at != 0 && oidx == stop_at;
    meta_tvalid = midx < mq.size() && $urandom_range(99) < v_pct;
    meta_tdata = midx < mq.size() ? mq[midx] : '0;
    data_tvalid = didx < dq.size() && $urandom_range(99) < v_pct;
    data_tdata = didx < dq.size() ? dq[didx] : '0;
    axis_out_tready = $urandom_range(99) < r_pct;
    #1;
    cyc++;
    m_hs = meta_tvalid && meta_tready;
    d_hs = data_tvalid && data_tready;
    if (exp_done) begin
      vec++;
      assert (done === 1'b1) else begin miss++; $error("FAIL done_after_last: got %b want 1", done); end
      exp_done = 0;
    end
    if (done) done_cnt++;
    if (stalled) begin
      vec++;
      assert ({axis_out_tvalid, axis_out_tlast, axis_out_tdata} === {1'b1, prev_last, prev_data}) else begin
        miss++; $error("FAIL stall_hold: got %b/%h want %b/%h", axis_out_tlast, axis_out_tdata, prev_last, prev_data);
      end
    end
    if (axis_out_tvalid) begin
      if (full && seen_beat) begin
        vec++;
        assert (idle == (prev_beat_last ? GAP : 0)) else begin
          miss++; $error("FAIL idle_between_beats: got %0d want %0d", idle, prev_beat_last ? GAP : 0);
        end
      end
      idle = 0;
    end else idle++;
    if (axis_out_tvalid && axis_out_tready) begin
      want = oidx < eq.size() ? eq[oidx] : 'x;
      vec++;
      assert (oidx < eq.size() && axis_out_tdata === eq[oidx] && axis_out_tlast === el[oidx]) else begin
        miss++; $error("FAIL beat%0d: got %h/%b want %h/%b", oidx, axis_out_tdata, axis_out_tlast, want, oidx < eq.size() ? el[oidx] : 1'bx);
      end
      oidx++;
      seen_beat = 1;
      prev_beat_last = axis_out_tlast;
      if (axis_out_tlast && oidx == eq.size()) exp_done = 1;
    end
    stalled = axis_out_tvalid && !axis_out_tready;
    prev_data = axis_out_tdata;
    prev_last = axis_out_tlast;
    if (tvalid2) begin
      v2_cnt++; v2_last = cyc;
      if (v2_first < 0) v2_first = cyc;
      if (tlast2) l2_cnt++;
    end
    if (done2) done2_cnt++;
  endtask

  task automatic run(input int b, input int p_cfg, input int p_exp, input int p_src,
                     input int vp, input int rp, input int stop_idx, input int busy_start, input string tag);
    int n;
    build(b, p_exp, p_src);
    cfg_num_packets = CW'(p_cfg);
    v_pct = vp; r_pct = rp; full = vp == 100 && rp == 100; stop_at = stop_idx;
    start_req = 1;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      if (n == busy_start) start_req = 1;
      tick();
      n++;
    end
    repeat (8) tick();
    stop_at = 0;
    vec++;
    assert (done_cnt == 1) else begin miss++; $error("FAIL %s done_pulses: got %0d want 1", tag, done_cnt); end
    vec++;
    assert (busy === 1'b0) else begin miss++; $error("FAIL %s busy_end: got %b want 0", tag, busy); end
    vec++;
    assert (oidx == eq.size()) else begin miss++; $error("FAIL %s beat_total: got %0d want %0d", tag, oidx, eq.size()); end
    vec++;
    assert (pkt_count === CW'(p_exp)) else begin miss++; $error("FAIL %s pkt_count: got %0d want %0d", tag, pkt_count, p_exp); end
  endtask

  initial begin
    int n;
    cyc = 0; v2_first = -1; v2_cnt = 0; v2_last = 0; l2_cnt = 0; done2_cnt = 0;
    stop_at = 0; start_req = 0; start2_req = 0; v_pct = 0; r_pct = 100;
    build(1, 0, 0);
    repeat (2) @(negedge clk);
    vec++;
    assert ({axis_out_tvalid, axis_out_tlast, axis_out_tdata} === '0) else begin
      miss++; $error("FAIL reset_out: got %b/%b/%h want 0", axis_out_tvalid, axis_out_tlast, axis_out_tdata);
    end
    vec++;
    assert ({meta_tready, data_tready, busy, done, pkt_count} === '0) else begin
      miss++; $error("FAIL reset_ctrl: got %b%b%b%b/%0d want 0", meta_tready, data_tready, busy, done, pkt_count);
    end
    resetn = 1;
    repeat (2) tick();
    run(3, 1, 1, 1, 100, 100, 0, -1, "basic");
    run(2, 3, 3, 3, 100, 100, 0, 6, "multi_gap_busy_start");
    run(0, 2, 2, 2, 100, 100, 0, -1, "zero_beats");
    run(4, 0, 2, 3, 100, 100, 7, -1, "stop_continuous");
    run(int'($urandom_range(6, 1)), 4, 4, 4, 60, 30, 0, -1, "backpressure_a");
    run(int'($urandom_range(6, 1)), 3, 3, 3, 50, 30, 0, -1, "backpressure_b");
    // async reset in the middle of packet 2's payload
    build(5, 3, 3);
    cfg_num_packets = CW'(3);
    v_pct = 100; r_pct = 100; full = 1; start_req = 1;
    n = 0;
    while (oidx < 10 && n < 200) begin tick(); n++; end
    vec++;
    assert (oidx >= 10 && pkt_count === CW'(1)) else begin miss++; $error("FAIL pre_reset: got %0d beats pkt_count %0d want 10/1", oidx, pkt_count); end
    #2 resetn = 0;
    #1;
    vec++;
    assert ({axis_out_tvalid, busy, meta_tready, data_tready} === 4'b0) else begin
      miss++; $error("FAIL async_reset: got %b%b%b%b want 0000", axis_out_tvalid, busy, meta_tready, data_tready);
    end
    vec++;
    assert (pkt_count === '0) else begin miss++; $error("FAIL async_reset_pkt_count: got %0d want 0", pkt_count); end
    m_hs = 0; d_hs = 0; stalled = 0; exp_done = 0;
    @(negedge clk);
    resetn = 1;
    run(3, 2, 2, 2, 100, 100, 0, -1, "post_reset");
    // no-gap instance: back-to-back frames with always-valid sources and an always-ready sink
    cfg_payload_beats = CW'(2); cfg_num_packets = CW'(3);
    v2_first = -1; v2_cnt = 0; l2_cnt = 0; done2_cnt = 0; start2_req = 1;
    n = 0;
    while (done2_cnt == 0 && n < 200) begin tick(); n++; end
    repeat (4) tick();
    vec++;
    assert (v2_cnt == 9 && v2_last - v2_first + 1 == 9) else begin
      miss++; $error("FAIL nogap_span: got %0d beats over %0d cycles want 9/9", v2_cnt, v2_last - v2_first + 1);
    end
    vec++;
    assert (l2_cnt == 3 && pc2 === CW'(3) && done2_cnt == 1) else begin
      miss++; $error("FAIL nogap_count: got tlast %0d pkt_count %0d done %0d want 3/3/1", l2_cnt, pc2, done2_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
